// File: rtl/serial_lock_pkg.sv
// serial_lock_pkg: shared types and constants for the locked serial suite.
package serial_lock_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, GUARD} state_t;

    localparam logic [1:0] LOCK_PATTERN_DEF = 2'b10;
    localparam int START_BITS = 1;

    // Counter width that stays at least one bit for tiny ranges
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: valid/ready word handshake into the serializer.
interface serial_frame_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  data_ready;

    modport master (output data_in, data_valid, input data_ready);
    modport slave  (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/lock_key_gate.sv
// lock_key_gate: toggling lock state, key compare and output corruption XOR.
module lock_key_gate import serial_lock_pkg::*; #(
    parameter logic [1:0] LOCK_PATTERN = LOCK_PATTERN_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic keyinput0,
    input  logic line_bit,
    output logic tx_out
);
    logic q_q, q_d, key_ok;

    // Key path stays combinational so a wrong key shows up on the very same cycle
    always_comb begin
        q_d    = ~q_q;
        key_ok = keyinput0 == LOCK_PATTERN[q_q];
        tx_out = line_bit ^ ~key_ok;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) q_q <= 1'b0;
        else          q_q <= q_d;
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: frames parallel words as start bit, MSB-first data and guard idle
// on a key-locked serial line.
module serial_frame_tx import serial_lock_pkg::*; #(
    parameter int         DATA_WIDTH   = 8,
    parameter int         GUARD_CYCLES = 2,
    parameter logic [1:0] LOCK_PATTERN = LOCK_PATTERN_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    serial_frame_tx_if.slave bus,
    input  logic             keyinput0,
    output logic             tx_out,
    output logic             busy,
    output logic             frame_done
);
    localparam int BW = cnt_w(DATA_WIDTH);
    localparam int GW = cnt_w(GUARD_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LOAD   = BW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES > 0 ? GUARD_CYCLES - 1 : 0);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [GW-1:0]         guard_q, guard_d;
    logic                  ready_q, ready_d, line_q, line_d, last, accept;

    // The final line cycle of a frame also takes the next word, so frames can abut
    always_comb begin
        last    = (state_q == DATA && bit_q == '0 && GUARD_CYCLES == 0) ||
                  (state_q == GUARD && guard_q == '0);
        accept  = bus.data_valid && ready_q;
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        guard_d = guard_q;
        if (accept) begin
            state_d = START;
            shift_d = bus.data_in;
        end else if (last) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = BIT_LOAD;
                end
                DATA: begin
                    shift_d = shift_q << 1;
                    if (bit_q == '0) begin
                        state_d = GUARD;
                        guard_d = GUARD_LOAD;
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end
                GUARD:   guard_d = guard_q - 1'b1;
                default: ;
            endcase
        end
        ready_d = state_d == IDLE ||
                  (state_d == DATA && bit_d == '0 && GUARD_CYCLES == 0) ||
                  (state_d == GUARD && guard_d == '0);
        line_d  = state_d == START || (state_d == DATA && shift_d[DATA_WIDTH-1]);
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            guard_q <= '0;
            ready_q <= 1'b0;
            line_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            guard_q <= guard_d;
            ready_q <= ready_d;
            line_q  <= line_d;
        end

    assign bus.data_ready = ready_q;
    assign busy           = state_q != IDLE;
    assign frame_done     = state_q == DATA && bit_q == '0;

    lock_key_gate #(.LOCK_PATTERN(LOCK_PATTERN)) u_gate (
        .clock     (clock),
        .reset_n   (reset_n),
        .keyinput0 (keyinput0),
        .line_bit  (line_q),
        .tx_out    (tx_out)
    );
endmodule
